// File: rtl/controle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controle_pkg: shared states, classes and datapath select constants   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package controle_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'd0,
    ST_FETCH  = 5'd1,
    ST_DECODE = 5'd2,
    ST_EXEC_R = 5'd3,
    ST_EXEC_I = 5'd4,
    ST_ALU_WB = 5'd5,
    ST_ADDR   = 5'd6,
    ST_LD_MEM = 5'd7,
    ST_LD_WB  = 5'd8,
    ST_SD_MEM = 5'd9,
    ST_BRANCH = 5'd10,
    ST_LUI_WB = 5'd11,
    ST_JAL    = 5'd12,
    ST_HALT   = 5'd13,
    ST_ERROR  = 5'd31
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LD, CL_SD, CL_BR, CL_LUI, CL_JAL, CL_SYS, CL_ILL
  } iclass_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REGA  = 2'd1;
  localparam logic [1:0] SRCA_PCOLD = 2'd2;
  localparam logic [1:0] SRCA_ZERO  = 2'd3;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_IMM    = 2'd2;
  localparam logic [1:0] WB_PC     = 2'd3;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage
`default_nettype wire

// File: rtl/unidade_controle_decodificador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | decodificador_instr: opcode/funct fields -> class, legality, imm_type |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module decodificador_instr
  import controle_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] iclass,
  output logic       legal,
  output logic [2:0] imm_type
);

  always_comb begin
    iclass   = CL_ILL;
    legal    = 1'b0;
    imm_type = IMM_I;
    case (opcode)
      OP_R: begin
        iclass = CL_R;
        legal  = (funct7 == F7_BASE) || (funct7 == F7_ALT);
      end
      OP_IMM: begin
        iclass = CL_I;
        legal  = (funct3 == 3'b000);
      end
      OP_LOAD: begin
        iclass = CL_LD;
        legal  = (funct3 == 3'b011);
      end
      OP_STORE: begin
        iclass   = CL_SD;
        legal    = (funct3 == 3'b011);
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        iclass   = CL_BR;
        legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
        imm_type = IMM_SB;
      end
      OP_LUI: begin
        iclass   = CL_LUI;
        legal    = 1'b1;
        imm_type = IMM_U;
      end
      OP_JAL: begin
        iclass   = CL_JAL;
        legal    = 1'b1;
        imm_type = IMM_UJ;
      end
      OP_SYSTEM: begin
        iclass = CL_SYS;
        legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | unidade_controle: multicycle RV64I control FSM with memory wait count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module unidade_controle
  import controle_pkg::*;
#(
  parameter int MEM_LAT = 1
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic [4:0]  state_out,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        ab_load,
  output logic        alu_out_load,
  output logic        mdr_load,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        pc_src,
  output logic [2:0]  imm_type,
  output logic        halted,
  output logic        error
);

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [3:0] w_cls;
  logic       w_legal;
  logic       w_last;
  logic       w_mem_state;
  logic       w_taken;
  logic       w_unused;

  decodificador_instr u_dec (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7   (instr[31:25]),
    .iclass   (w_cls),
    .legal    (w_legal),
    .imm_type (imm_type)
  );

  assign w_unused    = ^{instr[24:15], instr[11:7]};
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_LD_MEM) || (r_state == ST_SD_MEM);
  assign w_taken     = ((instr[14:12] == 3'b000) && zero) || ((instr[14:12] == 3'b001) && !zero);
  assign state_out   = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
    end else begin
      // The counter returns to zero on each exit, so every memory state starts at 0
      r_cnt <= (w_mem_state && !w_last) ? r_cnt + 3'd1 : 3'd0;
      case (r_state)
        ST_RESET:  r_state <= ST_FETCH;
        ST_FETCH:  if (w_last) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (w_cls)
            CL_R:         r_state <= ST_EXEC_R;
            CL_I:         r_state <= w_legal ? ST_EXEC_I : ST_ERROR;
            CL_LD, CL_SD: r_state <= w_legal ? ST_ADDR : ST_ERROR;
            CL_BR:        r_state <= w_legal ? ST_BRANCH : ST_ERROR;
            CL_LUI:       r_state <= ST_LUI_WB;
            CL_JAL:       r_state <= ST_JAL;
            CL_SYS:       r_state <= ST_HALT;
            default:      r_state <= ST_ERROR;
          endcase
        end
        ST_EXEC_R: r_state <= w_legal ? ST_ALU_WB : ST_ERROR;
        ST_EXEC_I: r_state <= ST_ALU_WB;
        ST_ADDR:   r_state <= (w_cls == CL_LD) ? ST_LD_MEM : ST_SD_MEM;
        ST_LD_MEM: if (w_last) r_state <= ST_LD_WB;
        ST_SD_MEM: if (w_last) r_state <= ST_FETCH;
        ST_ALU_WB, ST_LD_WB, ST_BRANCH, ST_LUI_WB, ST_JAL: r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        ST_ERROR:  r_state <= ST_ERROR;
        default:   r_state <= ST_ERROR;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    ab_load      = 1'b0;
    alu_out_load = 1'b0;
    mdr_load     = 1'b0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_REGB;
    alu_op       = 3'b000;
    wb_sel       = WB_ALUOUT;
    pc_src       = 1'b0;
    halted       = (r_state == ST_HALT);
    error        = (r_state == ST_ERROR);
    case (r_state)
      ST_FETCH: begin
        if (w_last) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
        end
      end
      ST_DECODE: begin
        ab_load      = 1'b1;
        alu_out_load = 1'b1;
        alu_src_a    = SRCA_PCOLD;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
      end
      ST_EXEC_R: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_REGB;
        alu_op       = instr[30] ? ALU_SUB : ALU_ADD;
        alu_out_load = w_legal;
      end
      ST_EXEC_I, ST_ADDR: begin
        alu_src_a    = SRCA_REGA;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALU_ADD;
        alu_out_load = 1'b1;
      end
      ST_ALU_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALUOUT;
      end
      ST_LD_MEM: begin
        dmem_read = 1'b1;
        mdr_load  = w_last;
      end
      ST_LD_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      ST_SD_MEM: dmem_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_SUB;
        pc_write  = w_taken;
        pc_src    = w_taken;
      end
      ST_LUI_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
      end
      ST_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
      end
      default: ;
    endcase
    // Reset must block every datapath side effect, even mid-access
    if (reset) begin
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      ab_load      = 1'b0;
      alu_out_load = 1'b0;
      mdr_load     = 1'b0;
      dmem_read    = 1'b0;
      dmem_write   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_unidade_controle: directed scoreboard bench, MEM_LAT = 1 and 3     |
// | Rev 1.1                                                              |
// +----------------------------------------------------------------------+
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;

    logic [4:0] st1, st3;
    logic pcw1, irw1, rw1, ab1, aol1, mdr1, rd1, wr1, h1, e1;
    logic pcw3, irw3, rw3, ab3, aol3, mdr3, rd3, wr3, h3, e3;
    logic [1:0] sa1, sb1, wb1, sa3, sb3, wb3;
    logic [2:0] op1, im1, op3, im3;
    logic       ps1, ps3;

    always #5 clk = ~clk;

    unidade_controle #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .state_out(st1),
        .pc_write(pcw1), .ir_write(irw1), .reg_write(rw1), .ab_load(ab1),
        .alu_out_load(aol1), .mdr_load(mdr1), .dmem_read(rd1), .dmem_write(wr1),
        .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(op1), .wb_sel(wb1), .pc_src(ps1),
        .imm_type(im1), .halted(h1), .error(e1)
    );

    unidade_controle #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .state_out(st3),
        .pc_write(pcw3), .ir_write(irw3), .reg_write(rw3), .ab_load(ab3),
        .alu_out_load(aol3), .mdr_load(mdr3), .dmem_read(rd3), .dmem_write(wr3),
        .alu_src_a(sa3), .alu_src_b(sb3), .alu_op(op3), .wb_sel(wb3), .pc_src(ps3),
        .imm_type(im3), .halted(h3), .error(e3)
    );

    // {state, pc_write, ir_write, reg_write, ab_load, alu_out_load, mdr_load,
    //  dmem_read, dmem_write, halted, error, src_a, src_b, alu_op, wb_sel, pc_src, imm_type}
    logic [27:0] vec1, vec3;
    assign vec1 = {st1, pcw1, irw1, rw1, ab1, aol1, mdr1, rd1, wr1, h1, e1, sa1, sb1, op1, wb1, ps1, im1};
    assign vec3 = {st3, pcw3, irw3, rw3, ab3, aol3, mdr3, rd3, wr3, h3, e3, sa3, sb3, op3, wb3, ps3, im3};

    localparam logic [27:0] M_ALL   = 28'hFFFFFFF;
    localparam logic [27:0] M_NOIMM = 28'hFFFFFF8;
    localparam logic [27:0] M_STEN  = 28'hFFFE000;

    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] SUB = 3'b010;

    localparam logic [9:0] E_NONE  = 10'b0000000000;
    localparam logic [9:0] E_FETCH = 10'b1100000000;
    localparam logic [9:0] E_DEC   = 10'b0001100000;
    localparam logic [9:0] E_ALU   = 10'b0000100000;
    localparam logic [9:0] E_RW    = 10'b0010000000;
    localparam logic [9:0] E_RD    = 10'b0000001000;
    localparam logic [9:0] E_RDM   = 10'b0000011000;
    localparam logic [9:0] E_WR    = 10'b0000000100;
    localparam logic [9:0] E_BR    = 10'b1000000000;
    localparam logic [9:0] E_JAL   = 10'b1010000000;
    localparam logic [9:0] E_HALT  = 10'b0000000010;
    localparam logic [9:0] E_ERR   = 10'b0000000001;

    typedef struct {
        string       nm;
        int          d;
        logic [27:0] val;
        logic [27:0] msk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [27:0] v(input logic [4:0] st, input logic [9:0] en,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [2:0] op, input logic [1:0] wb,
                                      input logic pcs, input logic [2:0] imm);
        return {st, en, a, b, op, wb, pcs, imm};
    endfunction

    // Monitor: the controller presents a new output word every cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [27:0] act;
            e   = q.pop_front();
            act = (e.d == 1) ? vec1 : vec3;
            n_tests++;
            if ((act & e.msk) !== (e.val & e.msk)) begin
                n_fail++;
                $display("FAIL %s (dut%0d): got %h, expected %h (mask %h)", e.nm, e.d, act & e.msk, e.val & e.msk, e.msk);
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [27:0] val, input logic [27:0] msk);
        q.push_back('{nm, d, val, msk});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Leaves the bench one step after release: state still RESET this cycle
    task automatic start(input logic [31:0] i, input logic z);
        instr = i;
        zero  = z;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        idle(1);

        // add, MEM_LAT=1
        start(32'h00B50533, 1'b0);
        chk("add_reset",  1, v(5'd0, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_NOIMM);
        chk("add_fetch",  1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd0), M_NOIMM);
        chk("add_decode", 1, v(5'd2, E_DEC,   2'd2, 2'd2, ADD,  2'd0, 1'b0, 3'd0), M_NOIMM);
        chk("add_exec",   1, v(5'd3, E_ALU,   2'd1, 2'd0, ADD,  2'd0, 1'b0, 3'd0), M_NOIMM);
        chk("add_wb",     1, v(5'd5, E_RW,    2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_NOIMM);
        chk("add_next",   1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd0), M_NOIMM);

        // sub selects ALU_SUB; an unsupported funct7 writes nothing and traps
        start(32'h40B50533, 1'b0);
        idle(3);
        chk("sub_exec",   1, v(5'd3, E_ALU,   2'd1, 2'd0, SUB,  2'd0, 1'b0, 3'd0), M_NOIMM);
        start(32'h02B50533, 1'b0);
        idle(3);
        chk("rbad_exec",  1, v(5'd3, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        chk("rbad_err",   1, v(5'd31, E_ERR,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);

        // ld, MEM_LAT=3: 9 cycles from first FETCH to LD_WB
        start(32'h0005B503, 1'b0);
        chk("ld_reset",   3, v(5'd0, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_fetch0",  3, v(5'd1, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_fetch1",  3, v(5'd1, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_fetch2",  3, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_decode",  3, v(5'd2, E_DEC,   2'd2, 2'd2, ADD,  2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_addr",    3, v(5'd6, E_ALU,   2'd1, 2'd2, ADD,  2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_mem0",    3, v(5'd7, E_RD,    2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_mem1",    3, v(5'd7, E_RD,    2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_mem2",    3, v(5'd7, E_RDM,   2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);
        chk("ld_wb",      3, v(5'd8, E_RW,    2'd0, 2'd0, 3'd0, 2'd1, 1'b0, 3'd0), M_ALL);
        chk("ld_next",    3, v(5'd1, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_ALL);

        // reset held 3 cycles in the middle of LD_MEM
        start(32'h0005B503, 1'b0);
        idle(6);
        chk("ldr_mem",    3, v(5'd7, E_RD,    2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        reset = 1'b1;
        chk("ldr_hold0",  3, v(5'd7, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        chk("ldr_hold1",  3, v(5'd0, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        chk("ldr_hold2",  3, v(5'd0, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        reset = 1'b0;
        chk("ldr_rel",    3, v(5'd0, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);
        chk("ldr_fetch",  3, v(5'd1, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);

        // sd, MEM_LAT=3
        start(32'h00B53023, 1'b0);
        idle(5);
        chk("sd_addr",    3, v(5'd6, E_ALU,   2'd1, 2'd2, ADD,  2'd0, 1'b0, 3'd1), M_ALL);
        for (int i = 0; i < 3; i++)
            chk("sd_mem", 3, v(5'd9, E_WR,    2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd1), M_ALL);
        chk("sd_next",    3, v(5'd1, E_NONE,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd1), M_ALL);

        // beq taken / not taken, bne taken, MEM_LAT=1
        start(32'h00000463, 1'b1);
        idle(2);
        chk("beq_decode", 1, v(5'd2, E_DEC,   2'd2, 2'd2, ADD,  2'd0, 1'b0, 3'd2), M_ALL);
        chk("beq_taken",  1, v(5'd10, E_BR,   2'd1, 2'd0, SUB,  2'd0, 1'b1, 3'd2), M_ALL);
        chk("beq_next",   1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd2), M_ALL);
        start(32'h00000463, 1'b0);
        idle(3);
        chk("beq_ntaken", 1, v(5'd10, E_NONE, 2'd1, 2'd0, SUB,  2'd0, 1'b0, 3'd2), M_ALL);
        chk("beq_nnext",  1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd2), M_ALL);
        start(32'h00001463, 1'b0);
        idle(3);
        chk("bne_taken",  1, v(5'd10, E_BR,   2'd1, 2'd0, SUB,  2'd0, 1'b1, 3'd2), M_ALL);

        // jal and lui
        start(32'h0000006F, 1'b0);
        idle(1);
        chk("jal_fetch",  1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd4), M_ALL);
        chk("jal_decode", 1, v(5'd2, E_DEC,   2'd2, 2'd2, ADD,  2'd0, 1'b0, 3'd4), M_ALL);
        chk("jal_exec",   1, v(5'd12, E_JAL,  2'd0, 2'd0, 3'd0, 2'd3, 1'b1, 3'd4), M_ALL);
        chk("jal_next",   1, v(5'd1, E_FETCH, 2'd0, 2'd1, ADD,  2'd0, 1'b0, 3'd4), M_ALL);
        start(32'h000012B7, 1'b0);
        idle(3);
        chk("lui_wb",     1, v(5'd11, E_RW,   2'd0, 2'd0, 3'd0, 2'd2, 1'b0, 3'd3), M_ALL);

        // illegal opcode is sticky for 20 cycles; illegal load funct3 traps too
        start(32'hFFFFFFFF, 1'b0);
        idle(3);
        for (int i = 0; i < 20; i++)
            chk("err_sticky", 1, v(5'd31, E_ERR, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_NOIMM);
        start(32'h0005A503, 1'b0);
        idle(3);
        chk("lw_err",     1, v(5'd31, E_ERR,  2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_STEN);

        // ebreak halts
        start(32'h00100073, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++)
            chk("halt",   1, v(5'd13, E_HALT, 2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0), M_NOIMM);

        if ((st1 !== 5'd13) || (h1 !== 1'b1)) begin
            n_fail++;
            $display("FAIL halt_final: got state %0d halted %b, expected state 13 halted 1", st1, h1);
        end
        if (e1 !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_noerr: got error %b, expected 0", e1);
        end
        if (n_tests < 12) begin
            n_fail++;
            $display("FAIL coverage: got %0d checks, expected at least 12", n_tests);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        if (n_fail != 0)
            $fatal(1, "[TB] %0d failures", n_fail);
        $finish;
    end

endmodule
`default_nettype wire
